mem_port_arb: RTL and testbench

Single-port memory arbiter between instruction fetch and the execute-stage load/store unit. It sits between the two requesters and the one shared memory bus. It allows one outstanding bus transaction, latches the winning request and returns the response to its owner only. It also stalls the execute stage and discards fetch responses that a pipeline flush has made stale.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/mem_port_arb_sel.sv | 42 ++++
 rtl/mem_port_arb.sv | 135 +++++++++++++
 tb/tb_mem_port_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, access-size encoding and the
// memory-port arbiter state/owner types (visible to fetch and top level).
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Access-size encoding of the execute stage; fetches are always words.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_t;

  typedef enum logic {OWNER_IF, OWNER_LSU} arb_owner_t;

  // Latched bus request.
  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } arb_req_t;

endpackage

// File: rtl/mem_port_arb_sel.sv
// Winner selection for the memory-port arbiter (purely combinational).
// Optional feature macro: MEM_PORT_ARB_RR_EN (round-robin instead of LSU priority).
module mem_port_arb_sel
  import riscv_pkg::*;
(
  input  logic       if_req_i,
  input  logic       lsu_req_i,
  input  logic       flush_i,
  input  arb_owner_t last_owner,
  output logic       if_win,
  output logic       lsu_win
);

  // A flush makes any pending fetch stale, so fetch may not compete.
  logic if_cand;
  assign if_cand = if_req_i & ~flush_i;

`ifdef MEM_PORT_ARB_RR_EN
  // Round-robin: on contention the requester that did not win last time wins.
  always_comb begin
    if_win  = 1'b0;
    lsu_win = 1'b0;
    if (if_cand && lsu_req_i) begin
      if (last_owner == OWNER_LSU) if_win  = 1'b1;
      else                         lsu_win = 1'b1;
    end else begin
      if_win  = if_cand;
      lsu_win = lsu_req_i;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: the LSU always wins over fetch.
  always_comb begin
    lsu_win = lsu_req_i;
    if_win  = if_cand & ~lsu_req_i;
  end
`endif

endmodule

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between instruction fetch and the LSU.
// One outstanding bus transaction; response routed to its owner only;
// stale fetch responses after a flush are discarded.
// Optional feature macro: MEM_PORT_ARB_RR_EN (round-robin arbitration).
module mem_port_arb
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic            lsu_we_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic [2:0]      lsu_size_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            exe_stall_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  arb_state_t state, state_next;
  arb_owner_t owner;
  arb_owner_t last_owner;
  arb_req_t   req_q;
  logic       drop_q;
  logic       if_win, lsu_win;

  mem_port_arb_sel u_sel (
    .if_req_i   (if_req_i),
    .lsu_req_i  (lsu_req_i),
    .flush_i    (flush_i),
    .last_owner (last_owner),
    .if_win     (if_win),
    .lsu_win    (lsu_win)
  );

`ifdef MEM_PORT_ARB_RR_EN
  // Remember which requester won the most recent grant.
  always_ff @(posedge clk) begin
    if (!reset_n)       last_owner <= OWNER_IF;
    else if (lsu_gnt_o) last_owner <= OWNER_LSU;
    else if (if_gnt_o)  last_owner <= OWNER_IF;
  end
`else
  assign last_owner = OWNER_IF;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_next;
  end

  // Next state, grants and response routing.
  always_comb begin
    state_next   = state;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    case (state)
      ARB_IDLE: begin
        if_gnt_o  = reset_n & if_win;
        lsu_gnt_o = reset_n & lsu_win;
        if (if_win || lsu_win) state_next = ARB_REQ;
      end
      ARB_REQ: begin
        // A same-cycle rvalid cannot belong to this request; only the grant counts.
        if (mem_gnt_i) state_next = ARB_RSP;
      end
      ARB_RSP: begin
        if (mem_rvalid_i) begin
          state_next = ARB_IDLE;
          if (reset_n) begin
            if (owner == OWNER_LSU) begin
              lsu_rvalid_o = 1'b1;
              lsu_rdata_o  = mem_rdata_i;
            end else if (!(drop_q || flush_i)) begin
              // A flush in the response cycle itself is also honoured.
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Capture the winning request and its owner at grant time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q <= '0;
      owner <= OWNER_IF;
    end else if (lsu_gnt_o) begin
      req_q <= '{adr: lsu_adr_i, we: lsu_we_i, wdata: lsu_wdata_i, size: lsu_size_i};
      owner <= OWNER_LSU;
    end else if (if_gnt_o) begin
      req_q <= '{adr: if_adr_i, we: 1'b0, wdata: '0, size: SIZE_WORD};
      owner <= OWNER_IF;
    end
  end

  // Drop flag: a flush during an in-flight fetch marks its response stale.
  always_ff @(posedge clk) begin
    if (!reset_n)                                         drop_q <= 1'b0;
    else if (state == ARB_RSP && mem_rvalid_i)            drop_q <= 1'b0;
    else if (state != ARB_IDLE && owner == OWNER_IF && flush_i) drop_q <= 1'b1;
  end

  assign mem_req_o   = (state == ARB_REQ);
  assign mem_adr_o   = req_q.adr;
  assign mem_we_o    = req_q.we;
  assign mem_wdata_o = req_q.wdata;
  assign mem_size_o  = req_q.size;

  assign exe_stall_o = lsu_req_i & ~lsu_rvalid_o;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_i;
  logic [31:0] if_adr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [31:0] lsu_adr_i, lsu_wdata_i;
  logic [2:0]  lsu_size_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        exe_stall_o, flush_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_wdata_o;
  logic [2:0]  mem_size_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arb dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_adr_i(lsu_adr_i), .lsu_we_i(lsu_we_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_size_i(lsu_size_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .exe_stall_o(exe_stall_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  logic [69:0] obs;
  logic [67:0] obs_mem;
  assign obs     = {if_gnt_o, lsu_gnt_o, mem_req_o, if_rvalid_o, if_rdata_o,
                    lsu_rvalid_o, lsu_rdata_o, exe_stall_o};
  assign obs_mem = {mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o};

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_adr_i = '0;
    lsu_req_i = 0; lsu_adr_i = '0; lsu_we_i = 0; lsu_wdata_i = '0; lsu_size_i = '0;
    flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  // Stimulus only: finish the granted transaction on a zero-wait bus.
  task automatic bus_complete();
    if_req_i = 0; lsu_req_i = 0; flush_i = 0;
    mem_gnt_i = 1; tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = $urandom; tick();
    mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick(); settle();
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_out got=%h exp=0", obs); end
    n_cmp++; if (obs_mem !== '0) begin n_bad++; $display("FAIL reset_mem got=%h exp=0", obs_mem); end
    tick();
    reset_n = 1; settle();
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL post_reset_out got=%h exp=0", obs); end
    tick();
  endtask

  task automatic test_lone_fetch();
    if_req_i = 1; if_adr_i = 32'h100; settle();
    n_cmp++; if ({if_gnt_o, lsu_gnt_o, mem_req_o} !== 3'b100) begin n_bad++; $display("FAIL fetch_gnt got=%b exp=100", {if_gnt_o, lsu_gnt_o, mem_req_o}); end
    tick();
    if_req_i = 0; mem_gnt_i = 1; settle();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fetch_mem_req got=%b exp=1", mem_req_o); end
    n_cmp++; if (obs_mem !== {32'h100, 1'b0, 32'h0, 3'b010}) begin n_bad++; $display("FAIL fetch_mem_fields got=%h exp=%h", obs_mem, {32'h100, 1'b0, 32'h0, 3'b010}); end
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; settle();
    n_cmp++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL fetch_rsp got=%b/%h exp=1/deadbeef", if_rvalid_o, if_rdata_o); end
    n_cmp++; if ({lsu_rvalid_o, lsu_rdata_o, mem_req_o} !== '0) begin n_bad++; $display("FAIL fetch_rsp_other got=%b/%h/%b exp=0", lsu_rvalid_o, lsu_rdata_o, mem_req_o); end
    tick();
    mem_rvalid_i = 0; mem_rdata_i = '0; settle();
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL fetch_idle got=%h exp=0", obs); end
  endtask

  task automatic test_contention();
    if_req_i = 1; if_adr_i = 32'h200;
    lsu_req_i = 1; lsu_adr_i = 32'h1000; lsu_we_i = 0; lsu_size_i = 3'b010; settle();
    n_cmp++; if ({if_gnt_o, lsu_gnt_o} !== 2'b01) begin n_bad++; $display("FAIL contend_gnt got=%b exp=01", {if_gnt_o, lsu_gnt_o}); end
    tick();
    mem_gnt_i = 1; settle();
    n_cmp++; if ({mem_adr_o, if_gnt_o, exe_stall_o} !== {32'h1000, 1'b0, 1'b1}) begin n_bad++; $display("FAIL contend_req got=%h/%b/%b exp=1000/0/1", mem_adr_o, if_gnt_o, exe_stall_o); end
    tick();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678; settle();
    n_cmp++; if ({lsu_rvalid_o, lsu_rdata_o, if_rvalid_o, exe_stall_o} !== {1'b1, 32'h12345678, 1'b0, 1'b0}) begin n_bad++; $display("FAIL contend_rsp got=%b/%h/%b/%b exp=1/12345678/0/0", lsu_rvalid_o, lsu_rdata_o, if_rvalid_o, exe_stall_o); end
    tick();
    mem_rvalid_i = 0; lsu_req_i = 0; settle();
    n_cmp++; if ({if_gnt_o, lsu_gnt_o} !== 2'b10) begin n_bad++; $display("FAIL contend_fetch_later got=%b exp=10", {if_gnt_o, lsu_gnt_o}); end
    tick();
    if_req_i = 0; settle();
    n_cmp++; if ({mem_req_o, mem_adr_o} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL contend_fetch_adr got=%b/%h exp=1/200", mem_req_o, mem_adr_o); end
    bus_complete();
    // Lone LSU grant, then contention again.
    lsu_req_i = 1; lsu_adr_i = 32'h2000; settle();
    n_cmp++; if (lsu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL lone_lsu_gnt got=%b exp=1", lsu_gnt_o); end
    tick();
    bus_complete();
    if_req_i = 1; lsu_req_i = 1; settle();
`ifdef MEM_PORT_ARB_RR_EN
    n_cmp++; if ({if_gnt_o, lsu_gnt_o} !== 2'b10) begin n_bad++; $display("FAIL rr_contend got=%b exp=10", {if_gnt_o, lsu_gnt_o}); end
`else
    n_cmp++; if ({if_gnt_o, lsu_gnt_o} !== 2'b01) begin n_bad++; $display("FAIL prio_contend got=%b exp=01", {if_gnt_o, lsu_gnt_o}); end
`endif
    tick();
    bus_complete();
  endtask

  task automatic test_store_wait();
    lsu_req_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h3000; lsu_wdata_i = 32'hA5A5A5A5; lsu_size_i = 3'b010; settle();
    n_cmp++; if ({lsu_gnt_o, exe_stall_o} !== 2'b11) begin n_bad++; $display("FAIL store_gnt got=%b exp=11", {lsu_gnt_o, exe_stall_o}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_gnt_i = 0; settle();
      n_cmp++; if ({mem_req_o, exe_stall_o, obs_mem} !== {2'b11, 32'h3000, 1'b1, 32'hA5A5A5A5, 3'b010}) begin n_bad++; $display("FAIL store_wait%0d got=%b/%b/%h", i, mem_req_o, exe_stall_o, obs_mem); end
      tick();
    end
    mem_gnt_i = 1; settle();
    n_cmp++; if ({mem_req_o, exe_stall_o} !== 2'b11) begin n_bad++; $display("FAIL store_bus_gnt got=%b exp=11", {mem_req_o, exe_stall_o}); end
    tick();
    mem_gnt_i = 0; settle();
    n_cmp++; if ({mem_req_o, lsu_rvalid_o, exe_stall_o} !== 3'b001) begin n_bad++; $display("FAIL store_rsp_wait got=%b exp=001", {mem_req_o, lsu_rvalid_o, exe_stall_o}); end
    tick();
    mem_rvalid_i = 1; settle();
    n_cmp++; if ({lsu_rvalid_o, exe_stall_o, lsu_gnt_o} !== 3'b100) begin n_bad++; $display("FAIL store_ack got=%b exp=100", {lsu_rvalid_o, exe_stall_o, lsu_gnt_o}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_rsp();
    if_req_i = 1; if_adr_i = 32'h300; tick();
    if_req_i = 0; mem_gnt_i = 1; tick();
    mem_gnt_i = 0; flush_i = 1; settle();
    n_cmp++; if (if_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL flush_rsp_wait got=%b exp=0", if_rvalid_o); end
    tick();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D; if_req_i = 1; if_adr_i = 32'h304; settle();
    n_cmp++; if ({if_rvalid_o, if_rdata_o, if_gnt_o} !== '0) begin n_bad++; $display("FAIL flush_dropped got=%b/%h/%b exp=0", if_rvalid_o, if_rdata_o, if_gnt_o); end
    tick();
    mem_rvalid_i = 0; settle();
    n_cmp++; if (if_gnt_o !== 1'b1) begin n_bad++; $display("FAIL flush_next_gnt got=%b exp=1", if_gnt_o); end
    tick();
    bus_complete();
  endtask

  task automatic test_flush_idle();
    for (int k = 0; k < 2; k++) begin
      if_req_i = 1; lsu_req_i = 1; flush_i = 1; settle();
      n_cmp++; if ({if_gnt_o, lsu_gnt_o} !== 2'b01) begin n_bad++; $display("FAIL flush_idle%0d got=%b exp=01", k, {if_gnt_o, lsu_gnt_o}); end
      tick();
      bus_complete();
    end
    if_req_i = 1; flush_i = 1; settle();
    n_cmp++; if (if_gnt_o !== 1'b0) begin n_bad++; $display("FAIL flush_lone_fetch got=%b exp=0", if_gnt_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    if_req_i = 1; if_adr_i = 32'h400; tick();
    if_req_i = 0; settle();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_req got=%b exp=1", mem_req_o); end
    tick();
    reset_n = 0; if_req_i = 1; if_adr_i = 32'h500; settle();
    n_cmp++; if (if_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_gnt_in_reset got=%b exp=0", if_gnt_o); end
    tick();
    reset_n = 1; settle();
    n_cmp++; if ({mem_req_o, obs_mem, if_rvalid_o, lsu_gnt_o, lsu_rvalid_o, exe_stall_o} !== '0) begin n_bad++; $display("FAIL rstmid_outputs got=%b/%h exp=0", mem_req_o, obs_mem); end
    n_cmp++; if (if_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_fresh_gnt got=%b exp=1", if_gnt_o); end
    tick();
    settle();
    n_cmp++; if ({mem_req_o, mem_adr_o} !== {1'b1, 32'h500}) begin n_bad++; $display("FAIL rstmid_fresh_adr got=%b/%h exp=1/500", mem_req_o, mem_adr_o); end
    bus_complete();
  endtask

  // Randomized traffic checked against a transaction-level model.
  task automatic test_random();
    bit          m_pend = 0, m_acc = 0, m_drop = 0, m_own_lsu = 0, m_last_lsu = 0;
    logic [67:0] m_fields = '0;
    bit          if_c, e_if_gnt, e_lsu_gnt, e_mem_req, rsp, e_if_rv, e_lsu_rv, e_stall;
    logic [69:0] exp_obs;
    idle_inputs();
    reset_n = 0; tick();
    reset_n = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters: fetch holds until granted, LSU holds until its response.
      if (!if_req_i && $urandom_range(0, 9) < 4) begin
        if_req_i = 1; if_adr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req_i && $urandom_range(0, 9) < 3) begin
        lsu_req_i = 1; lsu_adr_i = $urandom; lsu_we_i = $urandom_range(0, 1);
        lsu_wdata_i = $urandom; lsu_size_i = 3'($urandom_range(0, 7));
      end
      flush_i      = ($urandom_range(0, 9) == 0);
      mem_gnt_i    = m_pend && !m_acc && $urandom_range(0, 1);
      mem_rvalid_i = m_pend && m_acc && $urandom_range(0, 1);
      mem_rdata_i  = $urandom;
      settle();
      if_c = if_req_i && !flush_i;
`ifdef MEM_PORT_ARB_RR_EN
      e_lsu_gnt = !m_pend && lsu_req_i && (!if_c || !m_last_lsu);
`else
      e_lsu_gnt = !m_pend && lsu_req_i;
`endif
      e_if_gnt  = !m_pend && if_c && !e_lsu_gnt;
      e_mem_req = m_pend && !m_acc;
      rsp       = m_pend && m_acc && mem_rvalid_i;
      e_lsu_rv  = rsp && m_own_lsu;
      e_if_rv   = rsp && !m_own_lsu && !(m_drop || flush_i);
      e_stall   = lsu_req_i && !e_lsu_rv;
      exp_obs = {e_if_gnt, e_lsu_gnt, e_mem_req, e_if_rv, (e_if_rv ? mem_rdata_i : 32'h0),
                 e_lsu_rv, (e_lsu_rv ? mem_rdata_i : 32'h0), e_stall};
      n_cmp++; if (obs !== exp_obs) begin n_bad++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, obs, exp_obs); end
      if (m_pend) begin
        n_cmp++; if (obs_mem !== m_fields) begin n_bad++; $display("FAIL rand_mem cyc=%0d got=%h exp=%h", cyc, obs_mem, m_fields); end
      end
      // Model update for the coming edge.
      if (!m_pend) begin
        if (e_lsu_gnt) begin
          m_pend = 1; m_own_lsu = 1; m_last_lsu = 1;
          m_fields = {lsu_adr_i, lsu_we_i, lsu_wdata_i, lsu_size_i};
        end else if (e_if_gnt) begin
          m_pend = 1; m_own_lsu = 0; m_last_lsu = 0;
          m_fields = {if_adr_i, 1'b0, 32'h0, 3'b010};
        end
      end else if (rsp) begin
        m_pend = 0; m_acc = 0; m_drop = 0;
      end else begin
        if (!m_acc && mem_gnt_i) m_acc = 1;
        if (!m_own_lsu && flush_i) m_drop = 1;
      end
      tick();
      if (e_if_gnt) begin
        if ($urandom_range(0, 1)) if_req_i = 0;
        else if_adr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (e_lsu_rv) lsu_req_i = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    tick();
    test_contention();
    test_store_wait();
    test_flush_rsp();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
